// File: rtl/l1_store_buffer.sv
// l1_store_buffer: in-order byte-masked store queue sitting in front of the
// L1 data memory write port. Drains one entry per cycle when L1 is not
// stalled and forwards pending bytes onto load data read from L1.
// Optional build macro STORE_COALESCE_EN: a store to the same word as the
// youngest pending entry merges into it instead of taking a new slot.
module l1_store_buffer #(
    parameter int DEPTH             = 4,
    parameter int LOGICAL_ADD_WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         st_valid,
    input  logic [31:0]                  st_addr,
    input  logic [3:0]                   st_mask,
    input  logic [31:0]                  st_data,
    output logic                         st_ready,
    output logic                         mem_write_en,
    output logic [31:0]                  mem_write_addr,
    output logic [3:0]                   mem_write_mask,
    output logic [31:0]                  mem_write_data,
    input  logic                         mem_stall,
    input  logic [31:0]                  ld_addr,
    input  logic [31:0]                  ld_mem_data,
    output logic [31:0]                  ld_data,
    output logic                         sb_empty,
    output logic [$clog2(DEPTH+1)-1:0]   sb_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } entry_t;

    entry_t           entry_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] young_idx;
    logic             push;
    logic             pop;
    logic             coalesce_hit;

    // Only word bits inside the L1 decode range take part in matching.
    logic unused_ld_addr_bits;
    assign unused_ld_addr_bits = ^{ld_addr[31:LOGICAL_ADD_WIDTH], ld_addr[1:0]};

    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return a[LOGICAL_ADD_WIDTH-1:2] == b[LOGICAL_ADD_WIDTH-1:2];
    endfunction

    // Drain side: the head entry is always presented; it pops whenever L1 takes it.
    assign mem_write_en   = (count_q != '0) && !mem_stall;
    assign pop            = mem_write_en;
    assign mem_write_addr = entry_q[head_q].addr;
    assign mem_write_mask = entry_q[head_q].mask;
    assign mem_write_data = entry_q[head_q].data;

    assign young_idx = tail_q - PTR_W'(1);

`ifdef STORE_COALESCE_EN
    // Merge is refused when the youngest entry is also the one leaving this cycle.
    assign coalesce_hit = st_valid && (count_q != '0)
                          && word_match(entry_q[young_idx].addr, st_addr)
                          && !((count_q == CNT_W'(1)) && mem_write_en);
    assign st_ready     = (count_q != FULL_CNT) || coalesce_hit;
`else
    assign coalesce_hit = 1'b0;
    assign st_ready     = (count_q != FULL_CNT);
`endif

    // Ready is based on registered occupancy only, so a pop never frees a slot in the same cycle.
    assign push     = st_valid && st_ready && !coalesce_hit;
    assign sb_empty = (count_q == '0);
    assign sb_count = count_q;

    // Next-state for pointers and occupancy.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards every pending store at once.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: write a new entry at tail, or merge into the youngest entry.
    // NOTE: the entry array is not reset; head/count define which slots are live, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[tail_q] <= '{addr: st_addr, mask: st_mask, data: st_data};
        end else if (coalesce_hit) begin
            entry_q[young_idx].mask <= entry_q[young_idx].mask | st_mask;
            for (int l = 0; l < 4; l++) begin
                if (st_mask[l]) entry_q[young_idx].data[l*8 +: 8] <= st_data[l*8 +: 8];
            end
        end
    end

    // Load forwarding: walk oldest to youngest so the youngest matching byte wins per lane.
    always_comb begin
        logic [PTR_W-1:0] fwd_idx;
        ld_data = ld_mem_data;
        fwd_idx = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && word_match(entry_q[fwd_idx].addr, ld_addr)) begin
                for (int l = 0; l < 4; l++) begin
                    if (entry_q[fwd_idx].mask[l]) ld_data[l*8 +: 8] = entry_q[fwd_idx].data[l*8 +: 8];
                end
            end
        end
    end

endmodule
